// File: rtl/proc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : proc_ctrl_pkg                                          |
// | Description : Shared types and constants for the 9-bit teaching      |
// |               processor control unit (states, opcodes, bus selects,  |
// |               instruction-register field positions).                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package proc_ctrl_pkg;

  // Instruction time steps; T0 is the fetch/idle step.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Opcode field values (IR[8:6]).
  typedef enum logic [2:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_MVNZ = 3'd6,
    OP_NOP  = 3'd7
  } opcode_t;

  // Gout encodings toward the bus multiplexer.
  localparam logic [1:0] GOUT_NONE = 2'b00;
  localparam logic [1:0] GOUT_G    = 2'b10;
  localparam logic [1:0] GOUT_GF   = 2'b01;

  // IR field bit positions: III XXX YYY.
  localparam int IR_OP_HI = 8;
  localparam int IR_OP_LO = 6;
  localparam int IR_X_HI  = 5;
  localparam int IR_X_LO  = 3;
  localparam int IR_Y_HI  = 2;
  localparam int IR_Y_LO  = 0;

  // True for the four-cycle arithmetic/logic instructions.
  function automatic logic is_alu(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_control_reg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reg_decoder                                            |
// | Description : Register index to one-hot select, gated by an enable.  |
// |               Output bit i corresponds to register Ri.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module reg_decoder #(
  parameter int NREG  = 8,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [0:NREG-1]  o_onehot
);

  // One comparator per register; all-zero when disabled.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    assign o_onehot[gi] = i_en && (i_idx == IDX_W'(gi));
  end

endmodule
`default_nettype wire

// File: rtl/proc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : proc_control                                           |
// | Description : Control unit for the 9-bit teaching processor. Holds   |
// |               the IR, steps each instruction through T0..T3 and      |
// |               drives bus selects and load enables combinationally.   |
// |               Optional macro MVNZ_EN turns opcode 110 into mvnz      |
// |               (conditional move on GNZ); otherwise 110 is a NOP.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module proc_control
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              GNZ,
  output logic [0:NREG-1]   Rout,
  output logic [1:0]        Gout,
  output logic              DINout,
  output logic [0:NREG-1]   Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              GFin,
  output logic              AddSub,
  output logic              LogicOp,
  output logic              Done
);

  localparam int IDX_W = $clog2(NREG);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_ir;
  opcode_t             w_op;
  logic [IDX_W-1:0]    w_x;
  logic [IDX_W-1:0]    w_y;
  logic                w_rout_en;
  logic [IDX_W-1:0]    w_rout_idx;
  logic                w_rin_en;
  logic [IDX_W-1:0]    w_rin_idx;

  assign w_op = opcode_t'(r_ir[IR_OP_HI:IR_OP_LO]);
  assign w_x  = r_ir[IR_X_HI:IR_X_LO];
  assign w_y  = r_ir[IR_Y_HI:IR_Y_LO];

`ifndef MVNZ_EN
  // GNZ only matters for mvnz; keep the port but leave it unconnected inside.
  logic w_unused_gnz;
  assign w_unused_gnz = GNZ;
`endif

  // State and IR registers; IR captures DIN only when a fetch is accepted in T0.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == T0) && Run) begin
        r_ir <= DIN;
      end
    end
  end

  // Next-state: single-cycle instructions finish in T1, ALU ops run to T3.
  always_comb begin
    w_next = T0;
    case (r_state)
      T0:      w_next = Run ? T1 : T0;
      T1:      w_next = is_alu(w_op) ? T2 : T0;
      T2:      w_next = is_alu(w_op) ? T3 : T0;
      default: w_next = T0;
    endcase
  end

  // Output decode from state and IR; T0 leaves every output low.
  always_comb begin
    w_rout_en  = 1'b0;
    w_rout_idx = '0;
    w_rin_en   = 1'b0;
    w_rin_idx  = '0;
    Gout       = GOUT_NONE;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    GFin       = 1'b0;
    AddSub     = 1'b0;
    LogicOp    = 1'b0;
    Done       = 1'b0;
    case (r_state)
      T1: begin
        case (w_op)
          OP_MV: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_y;
            w_rin_en   = 1'b1;
            w_rin_idx  = w_x;
            Done       = 1'b1;
          end
          OP_MVI: begin
            DINout    = 1'b1;
            w_rin_en  = 1'b1;
            w_rin_idx = w_x;
            Done      = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_x;
            Ain        = 1'b1;
          end
`ifdef MVNZ_EN
          OP_MVNZ: begin
            // Conditional move: the transfer happens only when G is non-zero.
            w_rout_en  = GNZ;
            w_rout_idx = w_y;
            w_rin_en   = GNZ;
            w_rin_idx  = w_x;
            Done       = 1'b1;
          end
`endif
          default: begin
            Done = 1'b1;
          end
        endcase
      end
      T2: begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_y;
            Gin        = 1'b1;
            AddSub     = r_ir[IR_OP_LO];
          end
          OP_AND, OP_OR: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_y;
            GFin       = 1'b1;
            LogicOp    = r_ir[IR_OP_LO];
          end
          default: begin
            w_rout_en = 1'b0;
          end
        endcase
      end
      T3: begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            Gout      = GOUT_G;
            w_rin_en  = 1'b1;
            w_rin_idx = w_x;
            Done      = 1'b1;
          end
          OP_AND, OP_OR: begin
            Gout      = GOUT_GF;
            w_rin_en  = 1'b1;
            w_rin_idx = w_x;
            Done      = 1'b1;
          end
          default: begin
            Gout = GOUT_NONE;
          end
        endcase
      end
      default: begin
        Done = 1'b0;
      end
    endcase
  end

  reg_decoder #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_rout_dec (
    .i_idx    (w_rout_idx),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

  reg_decoder #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_rin_dec (
    .i_idx    (w_rin_idx),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

endmodule
`default_nettype wire

// File: tb/tb_proc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_proc_control                                        |
// | Description : Self-checking bench for proc_control: directed vector  |
// |               table, reset/Run corner sequences and random programs  |
// |               checked against a per-instruction reference model.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_proc_control;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] DIN;
  logic       GNZ;
  logic [0:7] Rout;
  logic [1:0] Gout;
  logic       DINout;
  logic [0:7] Rin;
  logic       Ain, Gin, GFin, AddSub, LogicOp, Done;

  int checks = 0;
  int errors = 0;

  proc_control #(.DATA_W(9), .NREG(8)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .DIN     (DIN),
    .GNZ     (GNZ),
    .Rout    (Rout),
    .Gout    (Gout),
    .DINout  (DINout),
    .Rin     (Rin),
    .Ain     (Ain),
    .Gin     (Gin),
    .GFin    (GFin),
    .AddSub  (AddSub),
    .LogicOp (LogicOp),
    .Done    (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [0:7] rout;
    logic [1:0] gout;
    logic       dinout;
    logic [0:7] rin;
    logic       ain;
    logic       gin;
    logic       gfin;
    logic       addsub;
    logic       logicop;
    logic       done;
  } outv_t;

  typedef struct {
    logic [8:0] ir;
    logic [8:0] d1;
    logic       gnz;
    int         n;
    outv_t      exp[4];
  } vec_t;

  // Build an expected output word; ro/ri of -1 mean no register selected.
  function automatic outv_t mk(int ro, logic [1:0] go, logic di, int ri,
                               logic a, logic g, logic gf, logic as_,
                               logic lo, logic d);
    outv_t o;
    o = '0;
    if (ro >= 0) o.rout[ro] = 1'b1;
    if (ri >= 0) o.rin[ri]  = 1'b1;
    o.gout    = go;
    o.dinout  = di;
    o.ain     = a;
    o.gin     = g;
    o.gfin    = gf;
    o.addsub  = as_;
    o.logicop = lo;
    o.done    = d;
    return o;
  endfunction

  function automatic outv_t sample();
    outv_t o;
    o.rout    = Rout;
    o.gout    = Gout;
    o.dinout  = DINout;
    o.rin     = Rin;
    o.ain     = Ain;
    o.gin     = Gin;
    o.gfin    = GFin;
    o.addsub  = AddSub;
    o.logicop = LogicOp;
    o.done    = Done;
    return o;
  endfunction

  task automatic chk(input string nm, input outv_t act, input outv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rout=%b gout=%b din=%b rin=%b a/g/gf/as/lo/d=%b%b%b%b%b%b, expected rout=%b gout=%b din=%b rin=%b a/g/gf/as/lo/d=%b%b%b%b%b%b",
               nm, act.rout, act.gout, act.dinout, act.rin, act.ain, act.gin, act.gfin,
               act.addsub, act.logicop, act.done, exp.rout, exp.gout, exp.dinout,
               exp.rin, exp.ain, exp.gin, exp.gfin, exp.addsub, exp.logicop, exp.done);
    end
  endtask

  // Reference model: the cycle-by-cycle output list an instruction should produce.
  function automatic void model(input logic [8:0] ir, input logic g, output outv_t q[$]);
    logic [2:0] op;
    int x, y;
    op = ir[8:6];
    x  = int'(ir[5:3]);
    y  = int'(ir[2:0]);
    q  = {};
    case (op)
      3'd0: q.push_back(mk(y, 2'b00, 1'b0, x, 0, 0, 0, 0, 0, 1));
      3'd1: q.push_back(mk(-1, 2'b00, 1'b1, x, 0, 0, 0, 0, 0, 1));
      3'd2, 3'd3: begin
        q.push_back(mk(x, 2'b00, 1'b0, -1, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(y, 2'b00, 1'b0, -1, 0, 1, 0, op[0], 0, 0));
        q.push_back(mk(-1, 2'b10, 1'b0, x, 0, 0, 0, 0, 0, 1));
      end
      3'd4, 3'd5: begin
        q.push_back(mk(x, 2'b00, 1'b0, -1, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(y, 2'b00, 1'b0, -1, 0, 0, 1, 0, op[0], 0));
        q.push_back(mk(-1, 2'b01, 1'b0, x, 0, 0, 0, 0, 0, 1));
      end
      3'd6: begin
`ifdef MVNZ_EN
        if (g) q.push_back(mk(y, 2'b00, 1'b0, x, 0, 0, 0, 0, 0, 1));
        else   q.push_back(mk(-1, 2'b00, 1'b0, -1, 0, 0, 0, 0, 0, 1));
`else
        q.push_back(mk(-1, 2'b00, 1'b0, -1, 0, 0, 0, 0, 0, 1));
`endif
      end
      default: q.push_back(mk(-1, 2'b00, 1'b0, -1, 0, 0, 0, 0, 0, 1));
    endcase
  endfunction

  // Fetch from T0 then check each following cycle; Run is held at rm after fetch.
  // Entered and left just after a rising edge with the DUT in T0.
  task automatic exec(input logic [8:0] ir, input logic [8:0] d1, input logic g,
                      input logic rm, input outv_t eq[$], input string nm);
    Run = 1'b1;
    DIN = ir;
    GNZ = 1'($urandom_range(0, 1));
    @(negedge Clock);
    chk({nm, " T0"}, sample(), '0);
    @(posedge Clock); #1;
    Run = rm;
    DIN = d1;
    GNZ = g;
    foreach (eq[k]) begin
      @(negedge Clock);
      chk($sformatf("%s T%0d", nm, k + 1), sample(), eq[k]);
      @(posedge Clock); #1;
      DIN = 9'($urandom);
    end
    Run = 1'b0;
  endtask

  // Bus-driver and one-hot invariants, every cycle.
  always @(negedge Clock) begin
    checks++;
    if (($countones(Rout) + int'(Gout != 2'b00) + int'(DINout)) > 1 ||
        Gout == 2'b11 || $countones(Rin) > 1) begin
      errors++;
      $display("FAIL bus_invariant: rout=%b gout=%b dinout=%b rin=%b, expected at most one driver and one-hot Rin",
               Rout, Gout, DINout, Rin);
    end
  end

  vec_t  tbl[10];
  outv_t q[$];
  outv_t z;

  initial begin
    z = '0;
    // Directed table from the instruction definitions.
    tbl[0].ir = 9'b001_010_000; tbl[0].d1 = 9'h055; tbl[0].gnz = 0; tbl[0].n = 1;
    tbl[0].exp[0] = mk(-1, 2'b00, 1, 2, 0, 0, 0, 0, 0, 1);
    tbl[1].ir = 9'b000_101_001; tbl[1].d1 = 9'h000; tbl[1].gnz = 0; tbl[1].n = 1;
    tbl[1].exp[0] = mk(1, 2'b00, 0, 5, 0, 0, 0, 0, 0, 1);
    tbl[2].ir = 9'b011_000_111; tbl[2].d1 = 9'h1ff; tbl[2].gnz = 1; tbl[2].n = 3;
    tbl[2].exp[0] = mk(0, 2'b00, 0, -1, 1, 0, 0, 0, 0, 0);
    tbl[2].exp[1] = mk(7, 2'b00, 0, -1, 0, 1, 0, 1, 0, 0);
    tbl[2].exp[2] = mk(-1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3].ir = 9'b101_011_100; tbl[3].d1 = 9'h000; tbl[3].gnz = 0; tbl[3].n = 3;
    tbl[3].exp[0] = mk(3, 2'b00, 0, -1, 1, 0, 0, 0, 0, 0);
    tbl[3].exp[1] = mk(4, 2'b00, 0, -1, 0, 0, 1, 0, 1, 0);
    tbl[3].exp[2] = mk(-1, 2'b01, 0, 3, 0, 0, 0, 0, 0, 1);
    tbl[4].ir = 9'b010_110_010; tbl[4].d1 = 9'h000; tbl[4].gnz = 0; tbl[4].n = 3;
    tbl[4].exp[0] = mk(6, 2'b00, 0, -1, 1, 0, 0, 0, 0, 0);
    tbl[4].exp[1] = mk(2, 2'b00, 0, -1, 0, 1, 0, 0, 0, 0);
    tbl[4].exp[2] = mk(-1, 2'b10, 0, 6, 0, 0, 0, 0, 0, 1);
    tbl[5].ir = 9'b100_001_101; tbl[5].d1 = 9'h000; tbl[5].gnz = 0; tbl[5].n = 3;
    tbl[5].exp[0] = mk(1, 2'b00, 0, -1, 1, 0, 0, 0, 0, 0);
    tbl[5].exp[1] = mk(5, 2'b00, 0, -1, 0, 0, 1, 0, 0, 0);
    tbl[5].exp[2] = mk(-1, 2'b01, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[6].ir = 9'b000_011_011; tbl[6].d1 = 9'h000; tbl[6].gnz = 0; tbl[6].n = 1;
    tbl[6].exp[0] = mk(3, 2'b00, 0, 3, 0, 0, 0, 0, 0, 1);
    tbl[7].ir = 9'b111_010_001; tbl[7].d1 = 9'h000; tbl[7].gnz = 1; tbl[7].n = 1;
    tbl[7].exp[0] = mk(-1, 2'b00, 0, -1, 0, 0, 0, 0, 0, 1);
    tbl[8].ir = 9'b110_100_010; tbl[8].d1 = 9'h000; tbl[8].gnz = 0; tbl[8].n = 1;
    tbl[8].exp[0] = mk(-1, 2'b00, 0, -1, 0, 0, 0, 0, 0, 1);
    tbl[9].ir = 9'b110_100_010; tbl[9].d1 = 9'h000; tbl[9].gnz = 1; tbl[9].n = 1;
`ifdef MVNZ_EN
    tbl[9].exp[0] = mk(2, 2'b00, 0, 4, 0, 0, 0, 0, 0, 1);
`else
    tbl[9].exp[0] = mk(-1, 2'b00, 0, -1, 0, 0, 0, 0, 0, 1);
`endif

    // Reset: outputs low during reset, with Run already requesting.
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 9'b001_111_000;
    GNZ    = 1'b0;
    #2 chk("reset_t0", sample(), z);
    @(posedge Clock); #2;
    chk("reset_held", sample(), z);
    Run = 1'b0;
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(negedge Clock);
    chk("after_reset_idle", sample(), z);
    @(posedge Clock); #1;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      q = {};
      for (int k = 0; k < tbl[i].n; k++) q.push_back(tbl[i].exp[k]);
      exec(tbl[i].ir, tbl[i].d1, tbl[i].gnz, 1'b0, q, $sformatf("vec%0d", i));
    end
    // Fetch gap after Done: T0 outputs low even with Run high.
    Run = 1'b1;
    DIN = 9'b000_000_000;
    @(negedge Clock);
    chk("fetch_gap", sample(), z);
    @(posedge Clock); #1;
    Run = 1'b0;
    @(negedge Clock);
    chk("mv_r0_r0", sample(), mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge Clock); #1;

    // Asynchronous reset during T2 of an add aborts with no Done.
    Run = 1'b1;
    DIN = 9'b010_001_010;
    @(posedge Clock); #1;
    Run = 1'b0;
    @(negedge Clock);
    chk("abort T1", sample(), mk(1, 2'b00, 0, -1, 1, 0, 0, 0, 0, 0));
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("abort T2", sample(), mk(2, 2'b00, 0, -1, 0, 1, 0, 0, 0, 0));
    #2 Resetn = 1'b0;
    #1 chk("abort async", sample(), z);
    @(posedge Clock); #1;
    chk("abort held", sample(), z);
    Resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      chk($sformatf("abort idle%0d", k), sample(), z);
    end
    @(posedge Clock); #1;

    // Run held high through an add: no restart, no IR reload.
    model(9'b010_100_011, 1'b0, q);
    exec(9'b010_100_011, 9'b000_111_111, 1'b0, 1'b1, q, "add_run_high");
    // Back-to-back with Run held high.
    model(9'b001_110_000, 1'b0, q);
    exec(9'b001_110_000, 9'h123, 1'b0, 1'b1, q, "b2b_mvi");
    model(9'b100_010_110, 1'b0, q);
    exec(9'b100_010_110, 9'h000, 1'b0, 1'b1, q, "b2b_and");

    // Random programs with idle gaps and mid-instruction Run noise.
    for (int i = 0; i < 200; i++) begin
      logic [8:0] ir;
      logic       g;
      logic       rm;
      int         idle;
      ir   = 9'($urandom);
      g    = 1'($urandom_range(0, 1));
      rm   = 1'($urandom_range(0, 1));
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        Run = 1'b0;
        DIN = 9'($urandom);
        @(negedge Clock);
        chk("rand idle", sample(), z);
        @(posedge Clock); #1;
      end
      model(ir, g, q);
      exec(ir, 9'($urandom), g, rm, q, $sformatf("rand%0d ir=%b", i, ir));
    end

    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
